// File: rtl/i2c_spike_mon.sv
// Passive I2C bus monitor: measures low pulses on SCL/SDA, flags and counts spikes,
// and detects START/STOP. Optional high-pulse measurement under I2C_SPK_HIGH_PULSE_EN.

module i2c_spike_line #(
    parameter int SPIKE_MAX = 3,
    parameter int CNT_W     = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             line,
    input  logic             cnt_clr,
    output logic             lvl,
    output logic             lvl_d,
    output logic             end_evt,
    output logic [7:0]       end_width,
    output logic             spike,
    output logic [CNT_W-1:0] spike_cnt
);
    typedef enum logic {HI, LO} state_t;

    localparam logic [7:0] SPK_LIM = 8'(SPIKE_MAX);

    state_t     state;
    logic [2:0] sync_pipe;
    logic [7:0] lo_cnt;
    logic       fall;
    logic       rise;
    logic       hit;
`ifdef I2C_SPK_HIGH_PULSE_EN
    logic [7:0] hi_cnt;
    logic       seen_rise;
`endif

    // [0],[1] synchronizer, [2] delayed copy for edge detection; idle bus is high
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) sync_pipe <= '1;
        else        sync_pipe <= {sync_pipe[1:0], line};
    end

    assign lvl   = sync_pipe[1];
    assign lvl_d = sync_pipe[2];
    assign fall  = lvl_d & ~lvl;
    assign rise  = ~lvl_d & lvl;

    always_comb begin
        end_evt   = 1'b0;
        end_width = lo_cnt;
        if (state == LO && rise) end_evt = 1'b1;
`ifdef I2C_SPK_HIGH_PULSE_EN
        // a high pulse only counts once it was opened by a rising edge we saw
        if (state == HI && fall && seen_rise) begin
            end_evt   = 1'b1;
            end_width = hi_cnt;
        end
`endif
    end

    assign hit = end_evt && (end_width <= SPK_LIM);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= HI;
            lo_cnt    <= '0;
            spike     <= 1'b0;
            spike_cnt <= '0;
`ifdef I2C_SPK_HIGH_PULSE_EN
            hi_cnt    <= '0;
            seen_rise <= 1'b0;
`endif
        end else begin
            spike <= hit;
            if (cnt_clr)
                spike_cnt <= '0;
            else if (hit && spike_cnt != '1)
                spike_cnt <= spike_cnt + 1'b1;

            case (state)
                HI: begin
                    if (fall) begin
                        state  <= LO;
                        lo_cnt <= 8'd1;
                    end
`ifdef I2C_SPK_HIGH_PULSE_EN
                    else if (hi_cnt != 8'hFF) begin
                        hi_cnt <= hi_cnt + 8'd1;
                    end
`endif
                end
                LO: begin
                    if (rise) begin
                        state <= HI;
`ifdef I2C_SPK_HIGH_PULSE_EN
                        hi_cnt    <= 8'd1;
                        seen_rise <= 1'b1;
`endif
                    end else if (lo_cnt != 8'hFF) begin
                        lo_cnt <= lo_cnt + 8'd1;
                    end
                end
                default: state <= HI;
            endcase
        end
    end
endmodule

module i2c_spike_mon #(
    parameter int SPIKE_MAX = 3,
    parameter int CNT_W     = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             scl,
    input  logic             sda,
    input  logic             cnt_clr,
    output logic             scl_spike,
    output logic             sda_spike,
    output logic [CNT_W-1:0] scl_spike_cnt,
    output logic [CNT_W-1:0] sda_spike_cnt,
    output logic [7:0]       last_width,
    output logic             start_det,
    output logic             stop_det
);
    localparam int NUM_LANES = 2;  // lane 0 = SCL, lane 1 = SDA

    logic [NUM_LANES-1:0]            line_in;
    logic [NUM_LANES-1:0]            lvl;
    logic [NUM_LANES-1:0]            lvl_d;
    logic [NUM_LANES-1:0]            end_evt;
    logic [NUM_LANES-1:0]            spike;
    logic [NUM_LANES-1:0][7:0]       end_width;
    logic [NUM_LANES-1:0][CNT_W-1:0] spike_cnt;
    logic                            scl_steady_hi;
    logic                            sda_fall;
    logic                            sda_rise;

    assign line_in = {sda, scl};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        i2c_spike_line #(
            .SPIKE_MAX(SPIKE_MAX),
            .CNT_W    (CNT_W)
        ) u_line (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .line     (line_in[i]),
            .cnt_clr  (cnt_clr),
            .lvl      (lvl[i]),
            .lvl_d    (lvl_d[i]),
            .end_evt  (end_evt[i]),
            .end_width(end_width[i]),
            .spike    (spike[i]),
            .spike_cnt(spike_cnt[i])
        );
    end

    assign scl_spike     = spike[0];
    assign sda_spike     = spike[1];
    assign scl_spike_cnt = spike_cnt[0];
    assign sda_spike_cnt = spike_cnt[1];

    assign scl_steady_hi = lvl[0] & lvl_d[0];
    assign sda_fall      = lvl_d[1] & ~lvl[1];
    assign sda_rise      = ~lvl_d[1] & lvl[1];

    // registered on the same edge the lanes report their pulse end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_width <= '0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            start_det <= sda_fall & scl_steady_hi;
            stop_det  <= sda_rise & scl_steady_hi;
            if (end_evt[0])
                last_width <= end_width[0];
            else if (end_evt[1])
                last_width <= end_width[1];
        end
    end
endmodule

// File: tb/tb_i2c_spike_mon.sv
// Self-checking bench for i2c_spike_mon: pulse table plus hand-written corner sequences,
// spike events checked against a scoreboard of expected last_width values.

module tb_i2c_spike_mon;
    localparam int SPIKE_MAX = 3;
    localparam int CNT_W     = 8;

    logic             PCLK;
    logic             PRESET;
    logic             scl;
    logic             sda;
    logic             cnt_clr;
    logic             scl_spike;
    logic             sda_spike;
    logic [CNT_W-1:0] scl_spike_cnt;
    logic [CNT_W-1:0] sda_spike_cnt;
    logic [7:0]       last_width;
    logic             start_det;
    logic             stop_det;

    i2c_spike_mon #(.SPIKE_MAX(SPIKE_MAX), .CNT_W(CNT_W)) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .scl          (scl),
        .sda          (sda),
        .cnt_clr      (cnt_clr),
        .scl_spike    (scl_spike),
        .sda_spike    (sda_spike),
        .scl_spike_cnt(scl_spike_cnt),
        .sda_spike_cnt(sda_spike_cnt),
        .last_width   (last_width),
        .start_det    (start_det),
        .stop_det     (stop_det)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        bit on_sda;
        int width;
        int exp_spk;
        int exp_cscl;
        int exp_csda;
        int exp_lw;
        int exp_ss;
    } vec_t;

    vec_t vecs[8];
    int   q_scl[$];
    int   q_sda[$];
    int   checks = 0;
    int   errors = 0;
    int   n_scl = 0, n_sda = 0, n_start = 0, n_stop = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // one clock; samples outputs at the falling edge and drains the scoreboard
    task automatic tick();
        int e;
        @(negedge PCLK);
        if (!PRESET) begin
            if (scl_spike) begin
                n_scl++;
                if (q_scl.size() == 0) check("sb_scl_unexpected", 1, 0);
                else begin
                    e = q_scl.pop_front();
                    check("sb_scl_lw", int'(last_width), e);
                end
            end
            if (sda_spike) begin
                n_sda++;
                if (q_sda.size() == 0) check("sb_sda_unexpected", 1, 0);
                else begin
                    e = q_sda.pop_front();
                    check("sb_sda_lw", int'(last_width), e);
                end
            end
            if (start_det) n_start++;
            if (stop_det)  n_stop++;
        end
    endtask

    task automatic low_pulse(input bit on_sda, input int w);
        if (on_sda) sda = 1'b0; else scl = 1'b0;
        repeat (w) tick();
        if (on_sda) sda = 1'b1; else scl = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_scl_spike"}, int'(scl_spike), 0);
        check({tag, "_sda_spike"}, int'(sda_spike), 0);
        check({tag, "_scl_cnt"}, int'(scl_spike_cnt), 0);
        check({tag, "_sda_cnt"}, int'(sda_spike_cnt), 0);
        check({tag, "_last_width"}, int'(last_width), 0);
        check({tag, "_start"}, int'(start_det), 0);
        check({tag, "_stop"}, int'(stop_det), 0);
    endtask

    initial begin
        int s_scl, s_sda, s_st, s_sp;

        // {on_sda, width, spike pulses, scl cnt, sda cnt, last_width, start/stop each}
        vecs[0] = '{1'b0, 2, 1, 1, 0, 2, 0};
        vecs[1] = '{1'b0, 4, 0, 1, 0, 4, 0};
        vecs[2] = '{1'b1, 1, 1, 1, 1, 1, 1};
        vecs[3] = '{1'b1, 3, 1, 1, 2, 3, 1};
        vecs[4] = '{1'b0, 3, 1, 2, 2, 3, 0};
        vecs[5] = '{1'b1, 5, 0, 2, 2, 5, 1};
        vecs[6] = '{1'b0, 1, 1, 3, 2, 1, 0};
        vecs[7] = '{1'b1, 4, 0, 3, 2, 4, 1};

        PRESET  = 1'b1;
        scl     = 1'b1;
        sda     = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        PRESET = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) begin
            s_scl = n_scl; s_sda = n_sda; s_st = n_start; s_sp = n_stop;
            if (vecs[i].exp_spk != 0) begin
                if (vecs[i].on_sda) q_sda.push_back(vecs[i].width);
                else                q_scl.push_back(vecs[i].width);
            end
            low_pulse(vecs[i].on_sda, vecs[i].width);
            repeat (6) tick();
            check($sformatf("vec%0d_spikes", i),
                  vecs[i].on_sda ? n_sda - s_sda : n_scl - s_scl, vecs[i].exp_spk);
            check($sformatf("vec%0d_other_spikes", i),
                  vecs[i].on_sda ? n_scl - s_scl : n_sda - s_sda, 0);
            check($sformatf("vec%0d_scl_cnt", i), int'(scl_spike_cnt), vecs[i].exp_cscl);
            check($sformatf("vec%0d_sda_cnt", i), int'(sda_spike_cnt), vecs[i].exp_csda);
            check($sformatf("vec%0d_last_width", i), int'(last_width), vecs[i].exp_lw);
            check($sformatf("vec%0d_start", i), n_start - s_st, vecs[i].exp_ss);
            check($sformatf("vec%0d_stop", i), n_stop - s_sp, vecs[i].exp_ss);
        end

        // spike lands on the 3rd rising edge after the pin rises, for one cycle
        q_scl.push_back(2);
        low_pulse(1'b0, 2);
        tick(); check("lat_r1", int'(scl_spike), 0);
        tick(); check("lat_r2", int'(scl_spike), 0);
        tick(); check("lat_r3", int'(scl_spike), 1);
        tick(); check("lat_r4", int'(scl_spike), 0);
        check("lat_cnt", int'(scl_spike_cnt), 4);

        // long low pulse saturates the width counter
        s_scl = n_scl;
        low_pulse(1'b0, 300);
        repeat (6) tick();
        check("long_lw", int'(last_width), 255);
        check("long_spikes", n_scl - s_scl, 0);
        check("long_cnt", int'(scl_spike_cnt), 4);

        // back-to-back 1-cycle SDA spikes with SCL high
        s_sda = n_sda; s_st = n_start; s_sp = n_stop;
        for (int k = 0; k < 260; k++) begin
            q_sda.push_back(1);
            sda = 1'b0;
            tick();
            sda = 1'b1;
            tick();
        end
        repeat (6) tick();
        check("burst_spikes", n_sda - s_sda, 260);
        check("burst_sda_cnt", int'(sda_spike_cnt), 255);
        check("burst_start", n_start - s_st, 260);
        check("burst_stop", n_stop - s_sp, 260);
        check("burst_lw", int'(last_width), 1);

        // clear coinciding with a detected spike: pulse still fires, counts go to 0
        q_scl.push_back(2);
        low_pulse(1'b0, 2);
        tick();
        tick();
        cnt_clr = 1'b1;
        tick();
        check("clr_spike", int'(scl_spike), 1);
        check("clr_scl_cnt", int'(scl_spike_cnt), 0);
        check("clr_sda_cnt", int'(sda_spike_cnt), 0);
        cnt_clr = 1'b0;
        repeat (4) tick();
        check("clr_scl_cnt_hold", int'(scl_spike_cnt), 0);

        // both lines end their pulses on the same edge: SCL width wins last_width
        s_scl = n_scl; s_sda = n_sda;
        q_scl.push_back(2);
        q_sda.push_back(2);
        sda = 1'b0;
        tick();
        scl = 1'b0;
        tick();
        tick();
        sda = 1'b1;
        scl = 1'b1;
        repeat (6) tick();
        check("tie_scl_spikes", n_scl - s_scl, 1);
        check("tie_sda_spikes", n_sda - s_sda, 1);
        check("tie_scl_cnt", int'(scl_spike_cnt), 1);
        check("tie_sda_cnt", int'(sda_spike_cnt), 1);
        check("tie_lw", int'(last_width), 2);

        // reset mid-pulse, line still low for 2 cycles after release
        s_scl = n_scl;
        scl = 1'b0;
        repeat (5) tick();
        PRESET = 1'b1;
        tick();
        check_all_zero("rst_mid");
        tick();
        q_scl.push_back(2);
        PRESET = 1'b0;
        tick();
        tick();
        scl = 1'b1;
        repeat (6) tick();
        check("rst_rel_spikes", n_scl - s_scl, 1);
        check("rst_rel_scl_cnt", int'(scl_spike_cnt), 1);
        check("rst_rel_sda_cnt", int'(sda_spike_cnt), 0);
        check("rst_rel_lw", int'(last_width), 2);

        check("sb_scl_left", q_scl.size(), 0);
        check("sb_sda_left", q_sda.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
